load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's MEM stage and the word-wide data memory (128 x 32, combinational read, write at posedge when MemWrite=1 and MemRead=0).
- Turns byte/halfword/word load and store requests into word accesses, using read-modify-write for sub-word stores.
- Sign- or zero-extends load data and flags misaligned or out-of-range accesses without touching memory.

Parameters:
MEM_WORDS, 128, number of 32-bit words in the attached memory; valid word index is 0..MEM_WORDS-1
RANGE_CHECK, 1, when 1, addresses with word index >= MEM_WORDS are rejected with resp_err

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  core request valid
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_address  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle pulse, request complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size or out of range; valid with resp_valid
mem_address  output  32  {addr[31:2],2'b00}
mem_MemRead  output  1  memory read enable
mem_MemWrite  output  1  memory write enable
mem_WriteData  output  32  word to write
mem_ReadData  input  32  combinational read data from memory

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, all registered values cleared. req_ready=1 after reset. resp_valid, resp_err, resp_rdata, mem_* all 0.
- Reset mid-operation aborts the operation. mem_MemWrite is gated with ~reset, so no memory write occurs in the reset cycle. No resp_valid is produced for the aborted request.
- Accept: req_valid & req_ready at the edge latches address, size, write, unsigned and wdata. Request inputs are ignored outside IDLE.
- Error check at accept: half with addr[0]=1; word with addr[1:0]!=0; size 11; RANGE_CHECK=1 and addr[31:2] >= MEM_WORDS. Any of these -> go to RESP with err=1. No memory access.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE -> RESP on error.
  - IDLE -> LOAD on a load.
  - IDLE -> WRITE on a word store.
  - IDLE -> RMW_RD on a byte or half store.
  - LOAD -> RESP.
  - RMW_RD -> WRITE.
  - WRITE -> RESP.
  - RESP -> IDLE.
- LOAD: mem_MemRead=1, mem_MemWrite=0. mem_ReadData is captured at the end of the cycle. Lane is selected, then extended per req_unsigned.
- RMW_RD: mem_MemRead=1. mem_ReadData is captured, and the store lane is merged with wdata into a word register.
- WRITE: mem_MemWrite=1, mem_MemRead=0. mem_WriteData = wdata (word) or the merged word. The memory commits on the edge ending this cycle.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata and resp_err are held only in this cycle and are 0 otherwise.
- Lanes are little-endian:
  - byte k (addr[1:0]=k) = bits [8k+7:8k]
  - half h (addr[1]=h) = bits [16h+15:16h]
- Extension: byte sign bit is bit 7 of the lane; half sign bit is bit 15 of the lane. Word loads are passed through unchanged.
- Outside LOAD/RMW_RD/WRITE: mem_MemRead=0, mem_MemWrite=0, mem_address=0, mem_WriteData=0.
- Latency from accept edge N:
  - error: resp at cycle N+1
  - load and word store: resp at N+2
  - sub-word store: resp at N+3
- Throughput: a new request can be accepted on the edge ending RESP+1 (IDLE). No back-to-back overlap.
- A store followed by a load to the same word returns the new data, because the write commits before the load's LOAD cycle.

Test Plan:
- Reset with no request -> req_ready=1, resp_valid=0, mem_MemWrite=0 and mem_MemRead=0 every cycle.
- SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> word 4 = 0xDEADBEEF. LW resp_rdata=0xDEADBEEF, resp_valid exactly 2 cycles after accept.
- Word 4 = 0xDEADBEEF, then:
  - SB addr 0x11, data 0x55 -> word 4 = 0xDEAD55EF, resp 3 cycles after accept.
  - SH addr 0x12, data 0x1234 -> word 4 = 0x123455EF.
- Word 4 = 0x123455EF, then:
  - LB 0x10 -> 0xFFFFFFEF
  - LBU 0x10 -> 0x000000EF
  - LH 0x12 -> 0x00001234
  - LHU 0x10 -> 0x000055EF
- Misaligned and out-of-range:
  - LH 0x13 -> resp_err=1, resp_rdata=0, 1-cycle latency, mem_MemRead never high.
  - SW 0x202 -> resp_err=1, memory unchanged.
  - LW 0x200 with RANGE_CHECK=1 -> resp_err=1.
- Reset asserted during the WRITE cycle of SB to 0x20 -> mem_MemWrite stays 0, word 8 unchanged, no resp_valid, IDLE with req_ready=1 next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Sub-word stores use read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
    parameter int MEM_WORDS   = 128,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [31:0] mem_WriteData,
    input  logic [31:0] mem_ReadData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        mem_rd_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_err_d;
    logic [31:0] load_data_d;
    logic [31:0] merged_d;
    logic [4:0]  shift_d;
    logic [7:0]  byte_lane_d;
    logic [15:0] half_lane_d;
    logic [31:0] lane_mask_d;

    always_comb begin
        req_err_d = 1'b0;
        if (req_size == 2'b11)
            req_err_d = 1'b1;
        if (req_size == SZ_HALF && req_address[0])
            req_err_d = 1'b1;
        if (req_size == SZ_WORD && req_address[1:0] != 2'b00)
            req_err_d = 1'b1;
        if (RANGE_CHECK && ({2'b00, req_address[31:2]} >= 32'(MEM_WORDS)))
            req_err_d = 1'b1;
    end

    // Lane extraction and merge both work on the latched address and live read data.
    always_comb begin
        shift_d     = {addr_q[1:0], 3'b000};
        byte_lane_d = 8'(mem_ReadData >> shift_d);
        half_lane_d = addr_q[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
        case (size_q)
            SZ_BYTE: load_data_d = uns_q ? {24'b0, byte_lane_d}
                                         : {{24{byte_lane_d[7]}}, byte_lane_d};
            SZ_HALF: load_data_d = uns_q ? {16'b0, half_lane_d}
                                         : {{16{half_lane_d[15]}}, half_lane_d};
            default: load_data_d = mem_ReadData;
        endcase
        lane_mask_d = (size_q == SZ_BYTE) ? (32'h0000_00FF << shift_d)
                                          : (32'h0000_FFFF << shift_d);
        merged_d = (mem_ReadData & ~lane_mask_d) | ((wdata_q << shift_d) & lane_mask_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_address;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        if (req_err_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            mem_addr_q <= {req_address[31:2], 2'b00};
                            if (!req_write) begin
                                state_q  <= S_LOAD;
                                mem_rd_q <= 1'b1;
                            end else if (req_size == SZ_WORD) begin
                                state_q     <= S_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                state_q  <= S_RMW_RD;
                                mem_rd_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    state_q      <= S_RESP;
                    mem_rd_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_data_d;
                end
                S_RMW_RD: begin
                    state_q     <= S_WRITE;
                    mem_rd_q    <= 1'b0;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= merged_d;
                end
                S_WRITE: begin
                    state_q      <= S_RESP;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_address   = mem_addr_q;
    assign mem_MemRead   = mem_rd_q;
    // A reset landing on the WRITE cycle must not let the memory commit.
    assign mem_MemWrite  = mem_we_q & ~reset;
    assign mem_WriteData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 128-word data memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_WriteData;
    logic [31:0] mem_ReadData;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:127];

    load_store_unit #(.MEM_WORDS(128), .RANGE_CHECK(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .mem_WriteData(mem_WriteData),
        .mem_ReadData(mem_ReadData)
    );

    always #5 clock = ~clock;

    assign mem_ReadData = mem[mem_address[8:2]];
    always @(posedge clock)
        if (mem_MemWrite && !mem_MemRead) mem[mem_address[8:2]] <= mem_WriteData;

    // Issues one request and follows it to its response (or a cycle budget).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic saw_rd, output logic saw_wr);
        int guard;
        @(negedge clock);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        req_write = w; req_size = sz; req_unsigned = u; req_address = a; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0; rd = '0; er = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            saw_rd |= mem_MemRead;
            saw_wr |= mem_MemWrite;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            @(posedge clock); #1;
        end
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL timeout addr=%h: no resp_valid within 8 cycles", a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            tests++;
            if (mem_MemWrite !== 1'b0) begin
                fails++; $display("FAIL reset_memwrite got=%b exp=0", mem_MemWrite);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            tests++;
            if ({req_ready, resp_valid, resp_err, mem_MemRead, mem_MemWrite} !== 5'b10000 ||
                resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_WriteData !== 32'h0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got rdy/rv/err/rd/wr=%b%b%b%b%b rdata=%h addr=%h exp=10000 0 0",
                         c, req_ready, resp_valid, resp_err, mem_MemRead, mem_MemWrite,
                         resp_rdata, mem_address);
            end
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er, srd, swr;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, srd, swr);
        tests++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h0 || swr !== 1'b1) begin
            fails++; $display("FAIL sw_resp got lat=%0d err=%b rdata=%h wr=%b exp lat=2 err=0 rdata=0 wr=1",
                              lat, er, rd, swr);
        end
        tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, srd, swr);
        tests++;
        if (lat != 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || swr !== 1'b0) begin
            fails++; $display("FAIL lw_resp got lat=%0d rdata=%h err=%b exp lat=2 rdata=deadbeef err=0",
                              lat, rd, er);
        end
        @(posedge clock); #1;
        tests++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            fails++; $display("FAIL resp_pulse got valid=%b rdata=%h exp 0 0", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_subword_store();
        int lat; logic [31:0] rd; logic er, srd, swr;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, rd, er, srd, swr);
        tests++;
        if (lat != 3 || er !== 1'b0 || mem[4] !== 32'hDEAD55EF) begin
            fails++; $display("FAIL sb got lat=%0d err=%b mem=%h exp lat=3 err=0 mem=dead55ef",
                              lat, er, mem[4]);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, rd, er, srd, swr);
        tests++;
        if (lat != 3 || er !== 1'b0 || mem[4] !== 32'h123455EF) begin
            fails++; $display("FAIL sh got lat=%0d err=%b mem=%h exp lat=3 err=0 mem=123455ef",
                              lat, er, mem[4]);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h8000ABCD, lat, rd, er, srd, swr);
        tests++;
        if (mem[5] !== 32'h8000ABCD) begin
            fails++; $display("FAIL sw5 got=%h exp=8000abcd", mem[5]);
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [8] = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h13, 32'h14, 32'h16, 32'h15};
        logic [1:0]  sizes [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        unss  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [8] = '{32'hFFFFFFEF, 32'h000000EF, 32'h00001234, 32'h000055EF,
                                   32'h00000012, 32'hFFFFABCD, 32'h00008000, 32'hFFFFFFAB};
        int lat; logic [31:0] rd; logic er, srd, swr;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, er, srd, swr);
            tests++;
            if (rd !== exps[i] || lat != 2 || er !== 1'b0) begin
                fails++; $display("FAIL load%0d addr=%h got rdata=%h lat=%0d err=%b exp rdata=%h lat=2 err=0",
                                  i, addrs[i], rd, lat, er, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er, srd, swr;
        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, rd, er, srd, swr);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || srd !== 1'b0) begin
            fails++; $display("FAIL lh_misaligned got err=%b rdata=%h lat=%0d rd=%b exp 1 0 1 0",
                              er, rd, lat, srd);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h202, 32'h11111111, lat, rd, er, srd, swr);
        tests++;
        if (er !== 1'b1 || lat != 1 || swr !== 1'b0) begin
            fails++; $display("FAIL sw_0x202 got err=%b lat=%0d wr=%b exp 1 1 0", er, lat, swr);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h22222222, lat, rd, er, srd, swr);
        tests++;
        if (er !== 1'b1 || swr !== 1'b0 || mem[4] !== 32'h123455EF) begin
            fails++; $display("FAIL sw_misaligned got err=%b wr=%b mem=%h exp 1 0 123455ef",
                              er, swr, mem[4]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, srd, swr);
        tests++;
        if (er !== 1'b1 || lat != 1 || srd !== 1'b0) begin
            fails++; $display("FAIL lw_range got err=%b lat=%0d rd=%b exp 1 1 0", er, lat, srd);
        end
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h33333333, lat, rd, er, srd, swr);
        tests++;
        if (er !== 1'b1 || swr !== 1'b0 || mem[4] !== 32'h123455EF) begin
            fails++; $display("FAIL size11 got err=%b wr=%b mem=%h exp 1 0 123455ef", er, swr, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, srd, swr;
        do_req(1'b1, 2'b10, 1'b0, 32'h1FC, 32'h0BADF00D, lat, rd, er, srd, swr);
        do_req(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, lat, rd, er, srd, swr);
        tests++;
        if (rd !== 32'h0BADF00D || er !== 1'b0 || lat != 2) begin
            fails++; $display("FAIL last_word got rdata=%h err=%b lat=%0d exp 0badf00d 0 2", rd, er, lat);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er, srd, swr;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, lat, rd, er, srd, swr);
        @(negedge clock);
        @(negedge clock);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_address = 32'h20; req_wdata = 32'h00000011; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        tests++;
        if (mem_MemWrite !== 1'b1) begin
            fails++; $display("FAIL abort_in_write got wr=%b exp=1", mem_MemWrite);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_MemWrite !== 1'b0) begin
            fails++; $display("FAIL abort_gate got wr=%b exp=0", mem_MemWrite);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        tests++;
        if (mem[8] !== 32'hCAFEF00D || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL abort_state got mem=%h rdy=%b rv=%b exp cafef00d 1 0",
                              mem[8], req_ready, resp_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            tests++;
            if (resp_valid !== 1'b0 || mem_MemWrite !== 1'b0) begin
                fails++; $display("FAIL abort_quiet cyc=%0d got rv=%b wr=%b exp 0 0", c, resp_valid, mem_MemWrite);
            end
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, srd, swr);
        tests++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            fails++; $display("FAIL abort_readback got rdata=%h err=%b exp cafef00d 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_store();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
